// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory read port shared by the fetch stage (master) and the memory (slave).
// A request completes in any cycle where req and ready are both high.
interface instruction_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic [31:0] data;
    logic        ready;

    modport master (
        output req,
        output addr,
        input  data,
        input  ready
    );

    modport slave (
        input  req,
        input  addr,
        output data,
        output ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues word-aligned reads to instruction memory
// and fills the IF/ID register, honouring stall, flush and EX redirects.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                            clock,
    input  logic                            reset_n,
    instruction_fetch_unit_if.master        imem,
    input  logic                            stall,
    input  logic                            flush,
    input  logic                            redirect_valid,
    input  logic [31:0]                     redirect_pc,
    output logic [31:0]                     pc,
    output logic [31:0]                     if_id_instr,
    output logic [31:0]                     if_id_pc_plus4,
    output logic                            if_id_valid
);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    fetch_state_t state, next_state;
    logic [31:0]  pending_pc, next_pending_pc;
    logic [31:0]  next_pc;
    logic [31:0]  pc_plus4;
    logic [31:0]  redirect_aligned;
    logic         capture;

    assign pc_plus4         = pc + 32'd4;
    assign redirect_aligned = redirect_pc & ~32'h3;
    assign imem.addr        = pc & ~32'h3;

    // Address only changes on a completed access or a redirect out of DISCARD,
    // so it stays stable while the memory is still working on a request.
    always_comb begin
        next_state      = state;
        next_pc         = pc;
        next_pending_pc = pending_pc;
        capture         = 1'b0;
        imem.req        = 1'b0;
        unique case (state)
            BOOT: begin
                next_state = FETCH;
            end
            FETCH: begin
                imem.req = 1'b1;
                if (redirect_valid) begin
                    if (imem.ready) begin
                        next_pc = redirect_aligned;
                    end else begin
                        next_pending_pc = redirect_aligned;
                        next_state      = DISCARD;
                    end
                end else if (imem.ready && !stall) begin
                    capture = 1'b1;
                    next_pc = pc_plus4;
                end
            end
            DISCARD: begin
                imem.req = 1'b1;
                if (redirect_valid) begin
                    next_pending_pc = redirect_aligned;
                end
                if (imem.ready) begin
                    next_pc    = redirect_valid ? redirect_aligned : pending_pc;
                    next_state = FETCH;
                end
            end
            default: begin
                next_state = BOOT;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            pending_pc <= 32'h0000_0000;
        end else begin
            state      <= next_state;
            pc         <= next_pc;
            pending_pc <= next_pending_pc;
        end
    end

    // Flush beats stall; a bubble is inserted whenever nothing was captured.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus4 <= 32'h0000_0000;
            if_id_valid    <= 1'b0;
        end else if (flush) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (stall) begin
            if_id_instr    <= if_id_instr;
            if_id_pc_plus4 <= if_id_pc_plus4;
            if_id_valid    <= if_id_valid;
        end else if (capture) begin
            if_id_instr    <= imem.data;
            if_id_pc_plus4 <= pc_plus4;
            if_id_valid    <= 1'b1;
        end else begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end
    end

endmodule
